// File: rtl/serial_pkg.sv
// Shared definitions for the serial transmitter and its matching receiver:
// FSM state encoding and the default frame/divider widths.
package serial_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } serial_state_t;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DIV_W         = 4;

endpackage

// File: rtl/bit_timer.sv
// Bit-period timer: counts 0..period and flags the first and last cycle of
// each bit period. A load restarts the count with a freshly captured period.
module bit_timer
    import serial_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [DIV_W-1:0] period,
    output logic             tick,
    output logic             first
);

    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] per;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt <= '0;
            per <= '0;
        end else if (load) begin
            cnt <= '0;
            per <= period;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + DIV_W'(1);
        end
    end

    assign tick  = (cnt == per);
    assign first = (cnt == '0);

endmodule

// File: rtl/bit_serializer_tx.sv
// Frame serializer: captures a WIDTH-bit word on start and shifts it out one
// bit per div+1 cycles, with registered valid/strobe/busy/done indications.
module bit_serializer_tx
    import serial_pkg::*;
#(
    parameter int   WIDTH      = DEFAULT_WIDTH,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] data_in,
    input  logic             msb_first,
    input  logic [DIV_W-1:0] div,
    output logic             d_out,
    output logic             d_valid,
    output logic             bit_strobe,
    output logic             busy,
    output logic             done
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    serial_state_t    state, state_next;
    logic [WIDTH-1:0] shreg, shreg_next, captured;
    logic [CNT_W-1:0] bit_cnt, bit_cnt_next;
    logic             d_out_next, d_valid_next, strobe_next, busy_next, done_next;
    logic             accept, tick, first, last_bit;

    function automatic logic [WIDTH-1:0] reverse_bits(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] r;
        for (int i = 0; i < WIDTH; i++) r[i] = v[WIDTH-1-i];
        return r;
    endfunction

    assign accept = (state == ST_IDLE) && start;

    // bit_cnt counts bits already started; on a bit's first cycle it has not
    // yet been bumped, so the last-bit test depends on whether we are there.
    assign last_bit = tick && (first ? (bit_cnt == CNT_W'(WIDTH - 1))
                                     : (bit_cnt == CNT_W'(WIDTH)));

    bit_timer u_bit_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (accept),
        .period  (div),
        .tick    (tick),
        .first   (first)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_next;
    end

    // The word is stored so that the bit on the wire is always shreg[0].
    always_comb begin
        state_next   = state;
        shreg_next   = shreg;
        bit_cnt_next = bit_cnt;
        d_out_next   = IDLE_LEVEL;
        d_valid_next = 1'b0;
        strobe_next  = 1'b0;
        busy_next    = 1'b0;
        done_next    = 1'b0;
        captured     = msb_first ? reverse_bits(data_in) : data_in;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_next   = ST_SHIFT;
                    shreg_next   = captured;
                    bit_cnt_next = '0;
                    d_out_next   = captured[0];
                    d_valid_next = 1'b1;
                    strobe_next  = 1'b1;
                    busy_next    = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (first) bit_cnt_next = bit_cnt + CNT_W'(1);
                if (last_bit) begin
                    state_next = ST_DONE;
                    done_next  = 1'b1;
                end else begin
                    d_valid_next = 1'b1;
                    busy_next    = 1'b1;
                    if (tick) begin
                        shreg_next  = shreg >> 1;
                        d_out_next  = shreg[1];
                        strobe_next = 1'b1;
                    end else begin
                        d_out_next = shreg[0];
                    end
                end
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            shreg      <= '0;
            bit_cnt    <= '0;
            d_out      <= IDLE_LEVEL;
            d_valid    <= 1'b0;
            bit_strobe <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            shreg      <= shreg_next;
            bit_cnt    <= bit_cnt_next;
            d_out      <= d_out_next;
            d_valid    <= d_valid_next;
            bit_strobe <= strobe_next;
            busy       <= busy_next;
            done       <= done_next;
        end
    end

endmodule

// File: doc/bit_serializer_tx.md
BIT_SERIALIZER_TX -- requirements
Module: bit_serializer_tx

Interface
REQ-001 Parameter WIDTH, default 8: number of bits per frame, legal range 2..16.
REQ-002 Parameter IDLE_LEVEL, default 1'b0: d_out level when no frame is being sent.
REQ-003 The port list SHALL be exactly as follows, one port per line as name, direction, width, meaning:
- clk  input  1  single clock; all state SHALL update on its rising edge.
- reset_n  input  1  synchronous, active-low reset.
- start  input  1  request to send one frame; sampled only in IDLE.
- data_in  input  WIDTH  frame payload, captured when start is accepted.
- msb_first  input  1  bit order, captured when start is accepted (1 = MSB first).
- div  input  4  bit period minus one, captured when start is accepted; each bit SHALL be held div+1 clk cycles.
- d_out  output  1  serial data line.
- d_valid  output  1  high while d_out carries a payload bit.
- bit_strobe  output  1  one-cycle pulse on the first cycle of each payload bit.
- busy  output  1  high in SHIFT.
- done  output  1  one-cycle pulse after the last bit period completes.

Function
REQ-004 The FSM SHALL have three states, IDLE, SHIFT and DONE, with these transitions:
- IDLE -> SHIFT on start = 1.
- SHIFT -> DONE when the last bit's period expires.
- DONE -> IDLE unconditionally after 1 cycle.
REQ-005 When start is accepted at rising edge N, the first payload bit SHALL appear on d_out in the cycle following edge N, with d_valid = 1 and bit_strobe = 1.
REQ-006 Each bit SHALL remain on d_out for exactly div+1 cycles. bit_strobe SHALL be high only in the first of those cycles.
REQ-007 A frame SHALL occupy exactly WIDTH*(div+1) cycles in SHIFT, followed by exactly 1 cycle in DONE.
REQ-008 In DONE: done = 1, busy = 0, d_valid = 0, d_out = IDLE_LEVEL.
REQ-009 In IDLE: d_out = IDLE_LEVEL; d_valid, bit_strobe, busy and done SHALL all be 0.
REQ-010 start SHALL be ignored in SHIFT and DONE. There is no queuing, and the frame in flight SHALL be unaffected.
REQ-011 Changes to data_in, msb_first or div after the start-accept edge SHALL NOT affect the frame in flight.
REQ-012 Back-to-back frames: a start held high through DONE SHALL be accepted in the following IDLE cycle. The minimum frame-to-frame gap is therefore 2 cycles at IDLE_LEVEL.
REQ-013 Bit counter width SHALL be clog2(WIDTH+1). Divider counter width SHALL be 4 bits; div = 0 gives 1 cycle per bit, div = 15 gives 16 cycles per bit.
REQ-014 All outputs SHALL be registered; there is no combinational path from any input to any output.

Reset
REQ-015 When reset_n = 0 at a rising edge, the block SHALL enter IDLE regardless of current state, including mid-frame. The frame is abandoned and there is no done pulse.
REQ-016 Reset values SHALL be: d_out = IDLE_LEVEL; d_valid, bit_strobe, busy and done all 0; internal shift register and counters all 0.
REQ-017 start asserted in the same cycle as reset_n = 0 SHALL be ignored.

Structure
REQ-018 The FSM state encoding (IDLE/SHIFT/DONE) SHALL live in a shared package, serial_pkg, for reuse by the matching receiver.
REQ-019 Default WIDTH and the div width (4) SHALL be declared as constants in serial_pkg.
REQ-020 Bit-period timing SHALL be implemented in one sub-module, bit_timer. Inputs: clk, reset_n, load, period[3:0]. Outputs: tick (last cycle of the period) and first (first cycle of the period).

Verification
REQ-021 The bench SHALL cover these directed scenarios, each stated as stimulus -> required response:
- WIDTH = 8, div = 0, msb_first = 1, data_in = 8'hA5, start pulse -> d_out = 1,0,1,0,0,1,0,1 on consecutive cycles; done pulses in cycle 9 after acceptance.
- data_in = 8'hA5, msb_first = 0, div = 3 -> d_out = 1,0,1,0,0,1,0,1 LSB first, each bit held 4 cycles; exactly 8 bit_strobe pulses; busy high for 32 cycles.
- Frame 8'h3C with div = 1; start re-pulsed at cycle 5 and data_in changed to 8'hFF -> the re-pulse is ignored; the transmitted frame is still 8'h3C; exactly one done pulse.
- Reset mid-frame: reset_n = 0 at cycle 4 of a div = 0 frame -> the next cycle shows d_out = IDLE_LEVEL and busy = 0; no done pulse; the next start sends a full frame correctly.
- start held high continuously, data_in = 8'h81, div = 0 -> frames repeat with a 2-cycle gap (DONE + IDLE); every frame is identical.
- IDLE_LEVEL = 1, div = 15 -> d_out = 1 when idle and in DONE; each bit held 16 cycles; frame length 128 cycles.
